sync_fifo_flex: RTL and testbench

//  Parametrised single-clock FIFO; successor to the team's basic sync FIFO.

---
 rtl/sync_fifo_pkg.sv | 24 ++
 rtl/sync_fifo_ram.sv | 37 +++
 rtl/sync_fifo_flex.sv | 104 ++++++++++
 tb/tb_sync_fifo_flex.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the sync_fifo family: a constant clog2, a power-of-two test,
// and an elaboration-time parameter check macro. FWFT is selected by SYNC_FIFO_FWFT_EN.
package sync_fifo_pkg;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

   function automatic bit is_pow2(input int value);
      return (value >= 2) && ((value & (value - 1)) == 0);
   endfunction

endpackage

`ifndef SYNC_FIFO_PARAM_CHECK
// Used inside a module body: stops elaboration on an unusable configuration.
`define SYNC_FIFO_PARAM_CHECK(D, AF, AE) \
   if (!sync_fifo_pkg::is_pow2(D) || ((AF) < 0) || ((AF) > (D)) || ((AE) < 0) || ((AE) > (D))) begin : g_param_check \
      $fatal(1, "sync_fifo: DEPTH must be a power of two >= 2 and thresholds within 0..DEPTH"); \
   end
`endif

// File: rtl/sync_fifo_ram.sv
// 1W/1R storage array: synchronous write; read is asynchronous with SYNC_FIFO_FWFT_EN,
// otherwise a reset-to-zero output register loaded on read.
module sync_fifo_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Storage deliberately has no reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

`ifdef SYNC_FIFO_FWFT_EN
   logic unused_rd_ctrl;
   assign unused_rd_ctrl = re ^ rst_n;
   assign rdata = mem[raddr];
`else
   // At full with a simultaneous write to the same slot this captures the old word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end
`endif

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with occupancy count, almost-full/empty flags and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read data.
module sync_fifo_flex
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2,
   parameter int PTR_WIDTH = clog2(DEPTH)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 wr_en_i,
   input  logic [WIDTH-1:0]     wdata_i,
   input  logic                 rd_en_i,
   output logic [WIDTH-1:0]     rdata_o,
   output logic                 full_o,
   output logic                 empty_o,
   output logic                 almost_full_o,
   output logic                 almost_empty_o,
   output logic [PTR_WIDTH:0]   count_o,
   output logic                 wr_error_o,
   output logic                 rd_error_o
);

   `SYNC_FIFO_PARAM_CHECK(DEPTH, AF_THRESH, AE_THRESH)

   localparam logic [PTR_WIDTH:0] CNT_ONE  = (PTR_WIDTH + 1)'(1);
   localparam logic [PTR_WIDTH:0] CNT_FULL = (PTR_WIDTH + 1)'(DEPTH);
   localparam logic [PTR_WIDTH:0] CNT_AF   = (PTR_WIDTH + 1)'(AF_THRESH);
   localparam logic [PTR_WIDTH:0] CNT_AE   = (PTR_WIDTH + 1)'(AE_THRESH);

   logic [PTR_WIDTH:0] wr_ptr;
   logic [PTR_WIDTH:0] rd_ptr;
   logic [PTR_WIDTH:0] count_next;
   logic               rd_acc;
   logic               wr_acc;
   logic [WIDTH-1:0]   ram_rdata;

   // A write at full still goes through when a read frees the slot this cycle.
   assign rd_acc = rd_en_i & ~empty_o;
   assign wr_acc = wr_en_i & (~full_o | rd_acc);

   always_comb begin
      count_next = count_o;
      if (wr_acc && !rd_acc)      count_next = count_o + CNT_ONE;
      else if (rd_acc && !wr_acc) count_next = count_o - CNT_ONE;
   end

   // Pointers carry an extra wrap bit so every entry is usable.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + CNT_ONE;
         if (rd_acc) rd_ptr <= rd_ptr + CNT_ONE;
      end
   end

   // Flags come from the next count so they line up with count_o.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         count_o        <= '0;
         full_o         <= 1'b0;
         empty_o        <= 1'b1;
         almost_full_o  <= 1'b0;
         almost_empty_o <= 1'b1;
         wr_error_o     <= 1'b0;
         rd_error_o     <= 1'b0;
      end else begin
         count_o        <= count_next;
         full_o         <= (count_next == CNT_FULL);
         empty_o        <= (count_next == '0);
         almost_full_o  <= (count_next >= CNT_AF);
         almost_empty_o <= (count_next <= CNT_AE);
         wr_error_o     <= wr_en_i & ~wr_acc;
         rd_error_o     <= rd_en_i & ~rd_acc;
      end
   end

   sync_fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (PTR_WIDTH)
   ) u_ram (
      .clk   (clk_i),
      .rst_n (rst_i),
      .we    (wr_acc),
      .waddr (wr_ptr[PTR_WIDTH-1:0]),
      .wdata (wdata_i),
      .re    (rd_acc),
      .raddr (rd_ptr[PTR_WIDTH-1:0]),
      .rdata (ram_rdata)
   );

`ifdef SYNC_FIFO_FWFT_EN
   assign rdata_o = empty_o ? '0 : ram_rdata;
`else
   assign rdata_o = ram_rdata;
`endif

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Self-checking bench for sync_fifo_flex: scoreboard queue of written words plus a
// count/flag model, compared at the falling edge after each directed step.
module tb_sync_fifo_flex;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int AF    = 14;
   localparam int AE    = 2;

   logic             clk_i   = 1'b0;
   logic             rst_i   = 1'b0;
   logic             wr_en_i = 1'b0;
   logic             rd_en_i = 1'b0;
   logic [WIDTH-1:0] wdata_i = '0;
   logic [WIDTH-1:0] rdata_o;
   logic             full_o, empty_o, almost_full_o, almost_empty_o;
   logic [4:0]       count_o;
   logic             wr_error_o, rd_error_o;

   int               checks = 0;
   int               errors = 0;
   logic [WIDTH-1:0] sb[$];
   int               mcount = 0;
   logic [WIDTH-1:0] exp_rdata = '0;
   logic             exp_wr_err = 1'b0;
   logic             exp_rd_err = 1'b0;

   sync_fifo_flex #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .AF_THRESH (AF),
      .AE_THRESH (AE)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .wr_en_i        (wr_en_i),
      .wdata_i        (wdata_i),
      .rd_en_i        (rd_en_i),
      .rdata_o        (rdata_o),
      .full_o         (full_o),
      .empty_o        (empty_o),
      .almost_full_o  (almost_full_o),
      .almost_empty_o (almost_empty_o),
      .count_o        (count_o),
      .wr_error_o     (wr_error_o),
      .rd_error_o     (rd_error_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      check({tag, ".count"},    32'(count_o),        32'(mcount));
      check({tag, ".full"},     32'(full_o),         32'(mcount == DEPTH));
      check({tag, ".empty"},    32'(empty_o),        32'(mcount == 0));
      check({tag, ".afull"},    32'(almost_full_o),  32'(mcount >= AF));
      check({tag, ".aempty"},   32'(almost_empty_o), 32'(mcount <= AE));
      check({tag, ".wr_error"}, 32'(wr_error_o),     32'(exp_wr_err));
      check({tag, ".rd_error"}, 32'(rd_error_o),     32'(exp_rd_err));
`ifdef SYNC_FIFO_FWFT_EN
      if (mcount != 0) check({tag, ".rdata"}, 32'(rdata_o), 32'(sb[0]));
`else
      check({tag, ".rdata"}, 32'(rdata_o), 32'(exp_rdata));
`endif
   endtask

   // Drives one cycle at the falling edge, updates the model, checks at the next falling edge.
   task automatic applyStimulus(input string tag, input logic wr, input logic [WIDTH-1:0] data,
                                input logic rd);
      logic rd_acc;
      logic wr_acc;
      rd_acc = rd && (mcount != 0);
      wr_acc = wr && ((mcount != DEPTH) || rd_acc);
      wr_en_i = wr;
      wdata_i = data;
      rd_en_i = rd;
      @(posedge clk_i);
      @(negedge clk_i);
      wr_en_i = 1'b0;
      rd_en_i = 1'b0;
      exp_wr_err = wr && !wr_acc;
      exp_rd_err = rd && !rd_acc;
      if (rd_acc) exp_rdata = sb.pop_front();
      if (wr_acc) sb.push_back(data);
      mcount = mcount + int'(wr_acc) - int'(rd_acc);
      checkOutput(tag);
   endtask

   initial begin
      // Reset state while rst_i is held low
      @(negedge clk_i);
      @(negedge clk_i);
      checkOutput("reset");
      rst_i = 1'b1;

      // Fill to full, then one rejected write
      for (int i = 0; i < DEPTH; i++) applyStimulus("fill", 1'b1, 8'(i), 1'b0);
      applyStimulus("overflow", 1'b1, 8'hEE, 1'b0);

      // Drain in order, then one rejected read
      for (int i = 0; i < DEPTH; i++) applyStimulus("drain", 1'b0, 8'h00, 1'b1);
      applyStimulus("underflow", 1'b0, 8'h00, 1'b1);

      // Simultaneous read+write at full
      for (int i = 0; i < DEPTH; i++) applyStimulus("refill", 1'b1, 8'(8'h10 + i), 1'b0);
      applyStimulus("full_rw", 1'b1, 8'hA5, 1'b1);
      for (int i = 0; i < DEPTH; i++) applyStimulus("drain_a5", 1'b0, 8'h00, 1'b1);

      // Simultaneous read+write at empty: write wins, read rejected
      applyStimulus("empty_rw", 1'b1, 8'h3C, 1'b1);
      applyStimulus("empty_rw_out", 1'b0, 8'h00, 1'b1);

      // Wrap-around at constant occupancy 8
      for (int i = 0; i < 8; i++) applyStimulus("pre_wrap", 1'b1, 8'(8'h60 + i), 1'b0);
      for (int i = 0; i < 40; i++) applyStimulus("wrap", 1'b1, 8'(8'h80 + i), 1'b1);

      // Asynchronous reset mid-burst at count 9
      applyStimulus("burst", 1'b1, 8'h99, 1'b0);
      wr_en_i = 1'b1;
      wdata_i = 8'h77;
      #2;
      rst_i = 1'b0;
      #1;
      sb.delete();
      mcount = 0;
      exp_rdata = '0;
      exp_wr_err = 1'b0;
      exp_rd_err = 1'b0;
      checkOutput("async_rst");
      @(negedge clk_i);
      wr_en_i = 1'b0;
      rst_i = 1'b1;

      // Normal operation resumes after reset
      applyStimulus("post_rst_wr", 1'b1, 8'h5A, 1'b0);
      applyStimulus("post_rst_rd", 1'b0, 8'h00, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
